// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO timer: register offsets, TCON bit positions
// and the offset decoder used by the top level.
package mmio_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    localparam logic [4:0] TH_OFF      = 5'h00;
    localparam logic [4:0] TL_OFF      = 5'h04;
    localparam logic [4:0] TCON_OFF    = 5'h08;
    localparam logic [4:0] SYSTICK_OFF = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [1:0] {
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_SYSTICK
    } reg_sel_e;

    typedef struct packed {
        logic     hit;
        reg_sel_e sel;
    } decode_t;

    // Offset includes the byte-lane bits, so misaligned accesses miss.
    function automatic decode_t decode_offset(input logic [4:0] off);
        decode_t d;
        d.hit = 1'b1;
        d.sel = REG_TH;
        case (off)
            TH_OFF:      d.sel = REG_TH;
            TL_OFF:      d.sel = REG_TL;
            TCON_OFF:    d.sel = REG_TCON;
            SYSTICK_OFF: d.sel = REG_SYSTICK;
            default:     d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: one-cycle tick every PRESCALE enabled cycles, held in phase 0
// while disabled.
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer with auto-reload, interrupt and a free-running cycle
// counter, answering MEM-stage loads/stores in a 32-byte window.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = PERIPH_BASE,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        interrupt
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        tcon_en;
    logic        tcon_ie;
    logic        tcon_is;

    decode_t dec;
    logic    wr_en;
    logic    wr_th;
    logic    wr_tl;
    logic    wr_tcon;
    logic    tick;
    logic    tl_step;
    logic    overflow;

    always_comb begin
        dec = decode_offset(Address[4:0]);
        if (Address[31:5] != BASE_ADDR[31:5]) begin
            dec.hit = 1'b0;
        end
    end

    assign hit     = dec.hit;
    assign wr_en   = MemWrite && dec.hit;
    assign wr_th   = wr_en && (dec.sel == REG_TH);
    assign wr_tl   = wr_en && (dec.sel == REG_TL);
    assign wr_tcon = wr_en && (dec.sel == REG_TCON);

    tick_divider #(
        .PRESCALE(PRESCALE)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .enable(tcon_en),
        .tick  (tick)
    );

    // A software TL write discards the tick, so it can neither count nor overflow.
    assign tl_step  = tick && !wr_tl;
    assign overflow = tl_step && (tl == 32'hFFFF_FFFF);

    // NOTE: every register here is a small flop resettable to zero; state uses
    // non-blocking assignments so all updates see the pre-edge values (the
    // reload below takes the old TH even when TH is written on the same edge).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th        <= '0;
            tl        <= '0;
            systick   <= '0;
            tcon_en   <= 1'b0;
            tcon_ie   <= 1'b0;
            tcon_is   <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            systick   <= systick + 32'd1;
            interrupt <= tcon_is && tcon_ie;

            if (wr_th) begin
                th <= Write_data;
            end

            if (wr_tl) begin
                tl <= Write_data;
            end else if (tl_step) begin
                tl <= overflow ? th : tl + 32'd1;
            end

            if (wr_tcon) begin
                tcon_en <= Write_data[TCON_EN];
                tcon_ie <= Write_data[TCON_IE];
            end

            // Hardware set beats a software write-0-to-clear on the same edge.
            if (overflow && tcon_ie) begin
                tcon_is <= 1'b1;
            end else if (wr_tcon && !Write_data[TCON_IS]) begin
                tcon_is <= 1'b0;
            end
        end
    end

    // NOTE: default assignment first keeps this combinational mux latch-free.
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && dec.hit) begin
            case (dec.sel)
                REG_TH:      Read_data = th;
                REG_TL:      Read_data = tl;
                REG_TCON:    Read_data = {29'h0, tcon_is, tcon_ie, tcon_en};
                REG_SYSTICK: Read_data = systick;
                default:     Read_data = 32'h0;
            endcase
        end
    end

endmodule
